// File: rtl/matvec_sched_if.sv
// matvec_sched_if: bundles every non-clock signal of matvec_sched.
//   Job control : start, rows, x_in (in); busy, done (out)
//   K stream    : k_valid, k_data (in); k_ready (out)
//   vec_mul side: mul_en, mul_k, mul_x (out); mul_y (in)
//   Y stream    : y_ready (in); y_valid, y_data, y_row, y_last (out)
// Directions above are as seen by the sequencer (modport slave); modport
// master is the surrounding environment's view.
interface matvec_sched_if #(
    parameter int C        = 8,
    parameter int W_X      = 8,
    parameter int W_K      = 8,
    parameter int MAX_ROWS = 256
) ();
    localparam int W_R   = $clog2(MAX_ROWS + 1);
    localparam int DEPTH = $clog2(C);
    localparam int W_Y   = W_X + W_K + DEPTH;

    logic                  start;
    logic [W_R-1:0]        rows;
    logic [C*W_X-1:0]      x_in;
    logic                  busy;
    logic                  done;
    logic                  k_valid;
    logic                  k_ready;
    logic [C*W_K-1:0]      k_data;
    logic                  mul_en;
    logic [C*W_K-1:0]      mul_k;
    logic [C*W_X-1:0]      mul_x;
    logic signed [W_Y-1:0] mul_y;
    logic                  y_valid;
    logic                  y_ready;
    logic signed [W_Y-1:0] y_data;
    logic [W_R-1:0]        y_row;
    logic                  y_last;

    modport slave (
        input  start, rows, x_in, k_valid, k_data, mul_y, y_ready,
        output busy, done, k_ready, mul_en, mul_k, mul_x,
               y_valid, y_data, y_row, y_last
    );

    modport master (
        output start, rows, x_in, k_valid, k_data, mul_y, y_ready,
        input  busy, done, k_ready, mul_en, mul_k, mul_x,
               y_valid, y_data, y_row, y_last
    );
endinterface

// File: rtl/matvec_sched.sv
// matvec_sched: sequences y = K*x through an external vec_mul dot-product
// pipeline of LAT = clog2(C)+1 stages. x is latched at job start, one K row
// per cycle is forwarded to vec_mul, a local tag pipeline tracks which row is
// in flight, and results leave as an ordered, row-tagged valid/ready stream.
// Backpressure on the Y stream freezes vec_mul (mul_en), the tags and the
// K input together.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - matvec_sched_if.slave (job control, K stream, vec_mul, Y stream)
module matvec_sched #(
    parameter int C        = 8,
    parameter int W_X      = 8,
    parameter int W_K      = 8,
    parameter int MAX_ROWS = 256
) (
    input  logic          clk,
    input  logic          rst,
    matvec_sched_if.slave bus
);
    localparam int W_R   = $clog2(MAX_ROWS + 1);
    localparam int DEPTH = $clog2(C);
    localparam int LAT   = DEPTH + 1;
    localparam int W_Y   = W_X + W_K + DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [W_R-1:0]        rows_q;
    logic [W_R-1:0]        issue_cnt_q, issue_cnt_d;
    logic [C*W_X-1:0]      x_q;
    logic                  done_q, done_d;
    logic                  load_job;

    logic [LAT-1:0]        tag_vld_q;
    logic [LAT-1:0]        tag_last_q;
    logic [W_R-1:0]        tag_row_q [LAT];

    logic                  y_valid_q;
    logic                  y_last_q;
    logic signed [W_Y-1:0] y_data_q;
    logic [W_R-1:0]        y_row_q;

    logic                  adv;
    logic                  mul_en;
    logic                  k_ready;
    logic                  k_hs;
    logic                  is_last_row;

    // Everything advances unless a result is sitting unaccepted.
    assign adv         = !(y_valid_q && !bus.y_ready);
    assign mul_en      = adv && (state_q != S_IDLE);
    assign k_ready     = (state_q == S_RUN) && adv && (issue_cnt_q < rows_q);
    assign k_hs        = bus.k_valid && k_ready;
    assign is_last_row = (issue_cnt_q == rows_q - W_R'(1));

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.k_ready = k_ready;
    assign bus.mul_en  = mul_en;
    assign bus.mul_x   = x_q;
    // Zero on non-handshake cycles so bubbles never carry stale K data.
    assign bus.mul_k   = k_hs ? bus.k_data : '0;
    assign bus.y_valid = y_valid_q;
    assign bus.y_data  = y_data_q;
    assign bus.y_row   = y_row_q;
    assign bus.y_last  = y_last_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        done_d      = 1'b0;
        load_job    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load_job    = 1'b1;
                        issue_cnt_d = '0;
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (k_hs) begin
                    issue_cnt_d = issue_cnt_q + W_R'(1);
                    if (is_last_row) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (y_valid_q && bus.y_ready && y_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            rows_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            done_q      <= done_d;
            if (load_job) begin
                rows_q <= bus.rows;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_job) begin
            x_q <= bus.x_in;
        end
    end

    // Tag pipeline: mirrors vec_mul's LAT stages, shifting only with mul_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_row_q[i] <= '0;
            end
        end else if (mul_en) begin
            tag_vld_q    <= {tag_vld_q[LAT-2:0], k_hs};
            tag_last_q   <= {tag_last_q[LAT-2:0], k_hs && is_last_row};
            tag_row_q[0] <= issue_cnt_q;
            for (int i = 1; i < LAT; i++) begin
                tag_row_q[i] <= tag_row_q[i-1];
            end
        end
    end

    // Output register: aligned with the last tag stage and vec_mul's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            y_data_q  <= '0;
            y_row_q   <= '0;
        end else if (mul_en) begin
            y_valid_q <= tag_vld_q[LAT-1];
            y_last_q  <= tag_last_q[LAT-1];
            y_data_q  <= bus.mul_y;
            y_row_q   <= tag_row_q[LAT-1];
        end
    end
endmodule

// File: tb/tb_matvec_sched.sv
// tb_matvec_sched: randomized scoreboard bench for matvec_sched with a
// behavioural vec_mul model. The K driver pushes the expected dot product,
// row index and last flag whenever a row is accepted; an independent monitor
// pops and compares on every Y handshake and checks stall, done and
// pass-through behaviour each cycle.
module tb_matvec_sched;
    localparam int C        = 8;
    localparam int W_X      = 8;
    localparam int W_K      = 8;
    localparam int MAX_ROWS = 256;
    localparam int W_R      = $clog2(MAX_ROWS + 1);
    localparam int DEPTH    = $clog2(C);
    localparam int LAT      = DEPTH + 1;
    localparam int W_Y      = W_X + W_K + DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matvec_sched_if #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_ROWS(MAX_ROWS)) bus ();

    matvec_sched #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_ROWS(MAX_ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural vec_mul: LAT-stage pipeline of the lane dot product.
    logic signed [W_Y-1:0] vm_p [LAT] = '{default: '0};

    function automatic logic signed [W_Y-1:0] vdot(input logic [C*W_K-1:0] k,
                                                   input logic [C*W_X-1:0] x);
        longint s = 0;
        for (int c = 0; c < C; c++) begin
            s += longint'($signed(k[c*W_K +: W_K])) * longint'($signed(x[c*W_X +: W_X]));
        end
        return W_Y'(s);
    endfunction

    always @(posedge clk) begin
        if (bus.mul_en) begin
            vm_p[0] <= vdot(bus.mul_k, bus.mul_x);
            for (int i = 1; i < LAT; i++) vm_p[i] <= vm_p[i-1];
        end
    end
    assign bus.mul_y = vm_p[LAT-1];

    typedef struct {
        longint y;
        int     row;
        bit     last;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               xv[C];
    int               job_x[C];
    int               kr[C];
    int               job_rows = 0;
    int               issued = 0;
    int               kmode = 0;
    int               kconst = 0;
    logic [C*W_X-1:0] job_xpk = '0;
    int               first_hs_cyc = -1;
    int               first_yv_cyc = -1;
    longint           last_y = 0;
    int               bp_mode = 0;
    bit               bp_used = 0;
    int               bp_left = 0;
    bit               exp_done_now = 0;
    bit               stall_prev = 0;
    longint           hold_data = 0;
    int               hold_row = 0;
    bit               hold_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [C*W_X-1:0] packx();
        logic [C*W_X-1:0] v;
        for (int c = 0; c < C; c++) v[c*W_X +: W_X] = xv[c][W_X-1:0];
        return v;
    endfunction

    function automatic logic [C*W_K-1:0] packk();
        logic [C*W_K-1:0] v;
        for (int c = 0; c < C; c++) v[c*W_K +: W_K] = kr[c][W_K-1:0];
        return v;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic void gen_row(input int r);
        for (int c = 0; c < C; c++) begin
            case (kmode)
                0:       kr[c] = r + 1;
                1:       kr[c] = kconst;
                default: kr[c] = rnd8();
            endcase
        end
    endfunction

    // Monitor: Y scoreboard, stall/hold, done timing and pass-through checks.
    always @(negedge clk) begin
        exp_t e;
        bit   nxt_done;
        if (rst) begin
            stall_prev   = 0;
            exp_done_now = 0;
        end else begin
            nxt_done = 0;
            chk("done", bus.done, exp_done_now);
            if (exp_done_now) chk("busy_at_done", bus.busy, 0);
            if (!bus.busy && bus.start && bus.rows == '0) nxt_done = 1;
            chk("mul_k", bus.mul_k, (bus.k_valid && bus.k_ready) ? bus.k_data : '0);
            if (bus.busy) chk("mul_x", bus.mul_x, job_xpk);
            if (stall_prev) begin
                chk("hold_valid", bus.y_valid, 1);
                chk("hold_data", bus.y_data, hold_data);
                chk("hold_row", bus.y_row, hold_row);
                chk("hold_last", bus.y_last, hold_last);
            end
            if (bus.y_valid && !bus.y_ready) begin
                chk("stall_mul_en", bus.mul_en, 0);
                chk("stall_k_ready", bus.k_ready, 0);
                stall_prev = 1;
                hold_data  = bus.y_data;
                hold_row   = bus.y_row;
                hold_last  = bus.y_last;
            end else begin
                stall_prev = 0;
            end
            if (bus.y_valid && first_yv_cyc < 0) first_yv_cyc = cyc;
            if (bus.y_valid && bus.y_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_y actual=row %0d data %0d required=no result",
                             bus.y_row, bus.y_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("y_data", bus.y_data, e.y);
                    chk("y_row", bus.y_row, e.row);
                    chk("y_last", bus.y_last, e.last);
                    last_y = bus.y_data;
                    if (e.last) nxt_done = 1;
                end
            end
            exp_done_now = nxt_done;
        end
    end

    // Backpressure driver.
    initial begin
        bus.y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: bus.y_ready = 1'b1;
                1: begin
                    if (bp_left > 0) begin
                        bus.y_ready = 1'b0;
                        bp_left--;
                    end else if (bus.y_valid && !bp_used) begin
                        bp_used     = 1;
                        bp_left     = 2;
                        bus.y_ready = 1'b0;
                    end else begin
                        bus.y_ready = 1'b1;
                    end
                end
                default: bus.y_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic start_job(input int nrows);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.rows  = W_R'(nrows);
        bus.x_in  = packx();
        for (int c = 0; c < C; c++) job_x[c] = xv[c];
        job_xpk  = packx();
        job_rows = nrows;
        issued   = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rows  = W_R'($urandom_range(0, MAX_ROWS));
        bus.x_in  = {$urandom, $urandom};
        if (nrows > 0) begin
            chk("start_busy", bus.busy, 1);
            chk("start_k_ready", bus.k_ready, 1);
        end else begin
            chk("zero_done", bus.done, 1);
            chk("zero_busy", bus.busy, 0);
        end
    endtask

    task automatic feed(input int count, input int gap);
        int fed = 0;
        int ph = 0;
        int guard = 0;
        bit hs;
        bit offer;
        exp_t e;
        gen_row(issued);
        while (fed < count) begin
            if (guard > 5000) begin
                checks++;
                failures++;
                $display("FAIL feed_timeout actual=%0d rows required=%0d rows", fed, count);
                break;
            end
            case (gap)
                0:       offer = 1;
                1:       offer = (ph % 3 == 0);
                default: offer = ($urandom_range(0, 1) == 1);
            endcase
            bus.k_valid = offer;
            bus.k_data  = offer ? packk() : {$urandom, $urandom};
            @(negedge clk);
            hs = offer && bus.k_ready;
            if (hs) begin
                e.y = 0;
                for (int c = 0; c < C; c++) e.y += longint'(job_x[c]) * longint'(kr[c]);
                e.row  = issued;
                e.last = (issued == job_rows - 1);
                exp_q.push_back(e);
                if (issued == 0) first_hs_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                issued++;
                fed++;
                gen_row(issued);
            end
            ph++;
            guard++;
        end
        bus.k_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_complete"}, (exp_q.size() == 0 && !bus.busy), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string name, input int nrows, input int gap);
        start_job(nrows);
        feed(nrows, gap);
        wait_idle(name);
    endtask

    initial begin
        bit seen;
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.start   = 1'b0;
        bus.rows    = '0;
        bus.x_in    = '0;
        bus.k_valid = 1'b0;
        bus.k_data  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_k_ready", bus.k_ready, 0);
        chk("rst_mul_en", bus.mul_en, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_y_last", bus.y_last, 0);
        chk("rst_y_data", bus.y_data, 0);
        chk("rst_y_row", bus.y_row, 0);
        rst = 1'b0;

        // Basic job with latency check
        foreach (xv[c]) xv[c] = 1;
        kmode = 0;
        bp_mode = 0;
        first_yv_cyc = -1;
        run_job("basic", 4, 0);
        chk("latency", first_yv_cyc - first_hs_cyc, LAT + 1);
        chk("basic_last_y", last_y, 32);

        // Backpressure: 3-cycle stall on the first result
        bp_used = 0;
        bp_left = 0;
        bp_mode = 1;
        run_job("backpressure", 6, 0);
        chk("bp_stalled", bp_used, 1);
        chk("bp_last_y", last_y, 48);
        bp_mode = 0;

        // Input gaps, plus start while busy is ignored
        start_job(3);
        bus.start = 1'b1;
        bus.rows  = W_R'(7);
        bus.x_in  = {$urandom, $urandom};
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_while_busy", bus.busy, 1);
        feed(3, 1);
        wait_idle("gaps");
        chk("gaps_last_y", last_y, 24);

        // Zero rows
        start_job(0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= bus.k_ready | bus.y_valid | bus.busy | bus.mul_en;
        end
        chk("zero_quiet", seen, 0);

        // Reset mid-job, then a fresh 2-row job
        start_job(6);
        feed(3, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_k_ready", bus.k_ready, 0);
        chk("mid_rst_mul_en", bus.mul_en, 0);
        chk("mid_rst_y_valid", bus.y_valid, 0);
        chk("mid_rst_y_data", bus.y_data, 0);
        chk("mid_rst_y_row", bus.y_row, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus.y_valid;
        end
        chk("post_rst_quiet", seen, 0);
        @(posedge clk);
        #1;
        foreach (xv[c]) xv[c] = rnd8();
        kmode = 2;
        run_job("after_rst", 2, 0);

        // Signed extremes
        foreach (xv[c]) xv[c] = -128;
        kmode = 1;
        kconst = -128;
        run_job("neg_extreme", 2, 0);
        chk("neg_extreme_y", last_y, 131072);

        // Mixed signs
        foreach (xv[c]) xv[c] = 127;
        run_job("mixed", 1, 0);
        chk("mixed_y", last_y, -130048);

        // Randomized jobs with gaps and backpressure
        kmode = 2;
        bp_mode = 2;
        for (int j = 0; j < 6; j++) begin
            foreach (xv[c]) xv[c] = rnd8();
            run_job("random", int'($urandom_range(1, 24)), 2);
        end
        foreach (xv[c]) xv[c] = rnd8();
        run_job("max_rows", MAX_ROWS, 0);
        bp_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
